vga_sync_gen: RTL and testbench

//  Parametrised VGA/DVI timing generator. Produces hsync, vsync, visible, col and row from
//  one system clock via an integer pixel-clock divider. Sync polarities are per-axis.
//  A programmable output delay aligns the timing signals with downstream pixel pipelines

---
 rtl/vga_sync_gen.sv | 131 +++++++++++++
 tb/tb_vga_sync_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA/DVI timing generator with pixel-clock divider, per-axis
//               sync polarity, frame counter and programmable output delay.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int   C_CLK_DIV      = 2,
    parameter int   C_PXL_VISIBLE  = 640,
    parameter int   C_PXL_FPORCH   = 16,
    parameter int   C_PXL_SYNCH    = 96,
    parameter int   C_PXL_TOTAL    = 800,
    parameter int   C_LINE_VISIBLE = 480,
    parameter int   C_LINE_FPORCH  = 9,
    parameter int   C_LINE_SYNCH   = 2,
    parameter int   C_LINE_TOTAL   = 520,
    parameter int   C_NB_PXLS      = 10,
    parameter int   C_NB_LINES     = 10,
    parameter int   C_NB_FRAME     = 8,
    parameter logic C_HSYNC_ACT    = 1'b0,
    parameter logic C_VSYNC_ACT    = 1'b0,
    parameter int   C_PIPE_DLY     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    output logic                  new_pxl_o,
    output logic                  visible_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic [C_NB_PXLS-1:0]  col_o,
    output logic [C_NB_LINES-1:0] row_o,
    output logic                  new_line_o,
    output logic                  new_frame_o,
    output logic [C_NB_FRAME-1:0] frame_cnt_o
);

    localparam int C_DIV_W  = (C_CLK_DIV > 1) ? $clog2(C_CLK_DIV) : 1;
    localparam int C_CNT_W  = C_NB_PXLS + C_NB_LINES + C_NB_FRAME;
    localparam int C_WORD_W = 6 + C_CNT_W;

    localparam logic [C_DIV_W-1:0]    C_DIV_MAX = C_DIV_W'(C_CLK_DIV - 1);
    localparam logic [C_NB_PXLS-1:0]  C_COL_MAX = C_NB_PXLS'(C_PXL_TOTAL - 1);
    localparam logic [C_NB_PXLS-1:0]  C_COL_VIS = C_NB_PXLS'(C_PXL_VISIBLE);
    localparam logic [C_NB_PXLS-1:0]  C_HS_BEG  = C_NB_PXLS'(C_PXL_VISIBLE + C_PXL_FPORCH);
    localparam logic [C_NB_PXLS-1:0]  C_HS_END  = C_NB_PXLS'(C_PXL_VISIBLE + C_PXL_FPORCH + C_PXL_SYNCH);
    localparam logic [C_NB_LINES-1:0] C_ROW_MAX = C_NB_LINES'(C_LINE_TOTAL - 1);
    localparam logic [C_NB_LINES-1:0] C_ROW_VIS = C_NB_LINES'(C_LINE_VISIBLE);
    localparam logic [C_NB_LINES-1:0] C_VS_BEG  = C_NB_LINES'(C_LINE_VISIBLE + C_LINE_FPORCH);
    localparam logic [C_NB_LINES-1:0] C_VS_END  = C_NB_LINES'(C_LINE_VISIBLE + C_LINE_FPORCH + C_LINE_SYNCH);

    // Output word layout: {new_pxl, new_line, new_frame, visible, hsync, vsync, col, row, frame}
    localparam logic [C_WORD_W-1:0] C_RST_WORD = {4'b0000, ~C_HSYNC_ACT, ~C_VSYNC_ACT, {C_CNT_W{1'b0}}};

    generate
        if (C_CLK_DIV < 1 || C_PIPE_DLY < 0 || C_PIPE_DLY > 15 || C_NB_FRAME < 1 ||
            C_PXL_TOTAL <= C_PXL_VISIBLE + C_PXL_FPORCH + C_PXL_SYNCH ||
            C_LINE_TOTAL <= C_LINE_VISIBLE + C_LINE_FPORCH + C_LINE_SYNCH ||
            (2 ** C_NB_PXLS) < C_PXL_TOTAL || (2 ** C_NB_LINES) < C_LINE_TOTAL) begin : g_bad_params
            $error("vga_sync_gen: invalid timing or counter-width parameters");
        end
    endgenerate

    logic [C_DIV_W-1:0]    div_q, div_d;
    logic [C_NB_PXLS-1:0]  col_q, col_d;
    logic [C_NB_LINES-1:0] row_q, row_d;
    logic [C_NB_FRAME-1:0] frame_q, frame_d;
    logic                  w_tick, w_col_max, w_row_max;
    logic                  w_vis, w_hs, w_vs, w_nl, w_nf;
    logic [C_WORD_W-1:0]   w_dec;
    logic [C_WORD_W-1:0]   pipe_q [0:C_PIPE_DLY];

    always_comb begin
        w_tick    = en_i && (div_q == C_DIV_MAX);
        w_col_max = (col_q == C_COL_MAX);
        w_row_max = (row_q == C_ROW_MAX);
        div_d     = div_q;
        col_d     = col_q;
        row_d     = row_q;
        frame_d   = frame_q;
        if (en_i) begin
            div_d = (div_q == C_DIV_MAX) ? '0 : div_q + 1'b1;
        end
        if (w_tick) begin
            col_d = w_col_max ? '0 : col_q + 1'b1;
            if (w_col_max) begin
                row_d = w_row_max ? '0 : row_q + 1'b1;
                if (w_row_max) begin
                    frame_d = frame_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_vis = (col_q < C_COL_VIS) && (row_q < C_ROW_VIS);
        w_hs  = (col_q >= C_HS_BEG && col_q < C_HS_END) ? C_HSYNC_ACT : ~C_HSYNC_ACT;
        w_vs  = (row_q >= C_VS_BEG && row_q < C_VS_END) ? C_VSYNC_ACT : ~C_VSYNC_ACT;
        w_nl  = w_tick && w_col_max;
        w_nf  = w_nl && w_row_max;
        w_dec = {w_tick, w_nl, w_nf, w_vis, w_hs, w_vs, col_q, row_q, frame_q};
    end

    // Counters are decoded together so every output shares one latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
            for (int i = 0; i <= C_PIPE_DLY; i++) begin
                pipe_q[i] <= C_RST_WORD;
            end
        end else begin
            div_q     <= div_d;
            col_q     <= col_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            pipe_q[0] <= w_dec;
            for (int i = 1; i <= C_PIPE_DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {new_pxl_o, new_line_o, new_frame_o, visible_o, hsync_o, vsync_o,
            col_o, row_o, frame_cnt_o} = pipe_q[C_PIPE_DLY];

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Checks three vga_sync_gen configurations against a timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    typedef struct packed {
        logic np, nl, nf, vis, hs, vs;
        logic [31:0] col, row, fc;
    } exp_t;

    typedef struct {
        int div, pv, pf, ps, pt, lv, lf, ls, lt, nf, dly;
        bit ha, va;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v = 3'b111;
    logic [2:0] en_v  = 3'b000;

    logic       np0, vis0, hs0, vs0, nl0, nf0;
    logic [9:0] col0, row0;
    logic [7:0] fc0;
    logic       np1, vis1, hs1, vs1, nl1, nf1;
    logic [9:0] col1, row1;
    logic [7:0] fc1;
    logic       np2, vis2, hs2, vs2, nl2, nf2;
    logic [2:0] col2, row2, fc2;

    vga_sync_gen u0 (
        .clk(clk), .rst(rst_v[0]), .en_i(en_v[0]), .new_pxl_o(np0), .visible_o(vis0),
        .hsync_o(hs0), .vsync_o(vs0), .col_o(col0), .row_o(row0),
        .new_line_o(nl0), .new_frame_o(nf0), .frame_cnt_o(fc0));

    vga_sync_gen #(.C_CLK_DIV(1), .C_PIPE_DLY(3)) u1 (
        .clk(clk), .rst(rst_v[1]), .en_i(en_v[1]), .new_pxl_o(np1), .visible_o(vis1),
        .hsync_o(hs1), .vsync_o(vs1), .col_o(col1), .row_o(row1),
        .new_line_o(nl1), .new_frame_o(nf1), .frame_cnt_o(fc1));

    vga_sync_gen #(
        .C_CLK_DIV(2), .C_PXL_VISIBLE(4), .C_PXL_FPORCH(1), .C_PXL_SYNCH(1), .C_PXL_TOTAL(8),
        .C_LINE_VISIBLE(2), .C_LINE_FPORCH(1), .C_LINE_SYNCH(1), .C_LINE_TOTAL(5),
        .C_NB_PXLS(3), .C_NB_LINES(3), .C_NB_FRAME(3),
        .C_HSYNC_ACT(1'b1), .C_VSYNC_ACT(1'b1), .C_PIPE_DLY(1)) u2 (
        .clk(clk), .rst(rst_v[2]), .en_i(en_v[2]), .new_pxl_o(np2), .visible_o(vis2),
        .hsync_o(hs2), .vsync_o(vs2), .col_o(col2), .row_o(row2),
        .new_line_o(nl2), .new_frame_o(nf2), .frame_cnt_o(fc2));

    cfg_t cfg [3];
    int   ecnt [3];
    exp_t hist [3][16];
    exp_t got [3];
    int   total = 0;
    int   bad   = 0;

    // Expected decode after e enabled clocks since reset: pixel index is e/div.
    function automatic exp_t mdl(input cfg_t c, input int e, input bit en);
        exp_t x;
        int   t;
        x     = '0;
        t     = e / c.div;
        x.col = 32'(t % c.pt);
        x.row = 32'((t / c.pt) % c.lt);
        x.fc  = 32'((t / (c.pt * c.lt)) % (1 << c.nf));
        x.np  = en && ((e % c.div) == c.div - 1);
        x.nl  = x.np && (x.col == 32'(c.pt - 1));
        x.nf  = x.nl && (x.row == 32'(c.lt - 1));
        x.vis = (x.col < 32'(c.pv)) && (x.row < 32'(c.lv));
        x.hs  = (x.col >= 32'(c.pv + c.pf) && x.col < 32'(c.pv + c.pf + c.ps)) ? c.ha : !c.ha;
        x.vs  = (x.row >= 32'(c.lv + c.lf) && x.row < 32'(c.lv + c.lf + c.ls)) ? c.va : !c.va;
        return x;
    endfunction

    function automatic exp_t rst_word(input cfg_t c);
        exp_t x;
        x    = '0;
        x.hs = !c.ha;
        x.vs = !c.va;
        return x;
    endfunction

    task automatic chk(input string nm, input int g, input int w);
        total++;
        if (g != w) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, g, w);
        end
    endtask

    // One clock: sample inputs at the edge, then update the model and compare all DUTs.
    task automatic step();
        logic [2:0] r_s, e_s;
        exp_t       w;
        @(posedge clk);
        r_s = rst_v;
        e_s = en_v;
        #1;
        got[0] = {np0, nl0, nf0, vis0, hs0, vs0, 32'(col0), 32'(row0), 32'(fc0)};
        got[1] = {np1, nl1, nf1, vis1, hs1, vs1, 32'(col1), 32'(row1), 32'(fc1)};
        got[2] = {np2, nl2, nf2, vis2, hs2, vs2, 32'(col2), 32'(row2), 32'(fc2)};
        for (int k = 0; k < 3; k++) begin
            if (r_s[k]) begin
                ecnt[k] = 0;
                for (int j = 0; j < 16; j++) hist[k][j] = rst_word(cfg[k]);
            end else begin
                for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = mdl(cfg[k], ecnt[k], e_s[k]);
                if (e_s[k]) ecnt[k]++;
            end
            w = hist[k][cfg[k].dly];
            total++;
            if (got[k] !== w) begin
                bad++;
                $display("FAIL model_u%0d @%0t: got np=%0d nl=%0d nf=%0d vis=%0d hs=%0d vs=%0d col=%0d row=%0d fc=%0d want np=%0d nl=%0d nf=%0d vis=%0d hs=%0d vs=%0d col=%0d row=%0d fc=%0d",
                         k, $time, got[k].np, got[k].nl, got[k].nf, got[k].vis, got[k].hs, got[k].vs,
                         got[k].col, got[k].row, got[k].fc, w.np, w.nl, w.nf, w.vis, w.hs, w.vs,
                         w.col, w.row, w.fc);
            end
        end
    endtask

    initial begin
        int npc, hlo, hfirst, hlast, l1, l2, found, frz_ok, nstr, lat;
        int prevh, prevc, fall, fcol, fprev, v3, v4;
        int nfc, vsc, vbad, hsc, visc, nf_re;
        int nfi [10];
        int fcs [10];

        cfg[0] = '{div:2, pv:640, pf:16, ps:96, pt:800, lv:480, lf:9, ls:2, lt:520, nf:8, dly:0, ha:1'b0, va:1'b0};
        cfg[1] = '{div:1, pv:640, pf:16, ps:96, pt:800, lv:480, lf:9, ls:2, lt:520, nf:8, dly:3, ha:1'b0, va:1'b0};
        cfg[2] = '{div:2, pv:4, pf:1, ps:1, pt:8, lv:2, lf:1, ls:1, lt:5, nf:3, dly:1, ha:1'b1, va:1'b1};
        for (int k = 0; k < 3; k++) begin
            ecnt[k] = 0;
            for (int j = 0; j < 16; j++) hist[k][j] = rst_word(cfg[k]);
        end
        for (int j = 0; j < 10; j++) begin
            nfi[j] = -1;
            fcs[j] = -1;
        end

        repeat (3) step();
        chk("rst_u0_hsync", int'(hs0), 1);
        chk("rst_u0_vsync", int'(vs0), 1);
        chk("rst_u0_vis", int'(vis0), 0);
        chk("rst_u2_hsync", int'(hs2), 0);

        // Default timing: pixel rate, hsync window and line period.
        rst_v[0] = 1'b0;
        en_v[0]  = 1'b1;
        npc = 0; hlo = 0; hfirst = -1; hlast = -1; l1 = -1; l2 = -1;
        for (int n = 1; n <= 3300; n++) begin
            step();
            if (n <= 100 && np0) npc++;
            if (n <= 1600 && !hs0) begin
                hlo++;
                if (hfirst < 0) hfirst = int'(col0);
                hlast = int'(col0);
            end
            if (nl0) begin
                if (l1 < 0) l1 = n;
                else if (l2 < 0) l2 = n;
            end
        end
        chk("np_per_100clk", npc, 50);
        chk("hsync_low_clks", hlo, 192);
        chk("hsync_first_col", hfirst, 656);
        chk("hsync_last_col", hlast, 751);
        chk("new_line_first", l1, 1600);
        chk("new_line_period", l2 - l1, 1600);

        // Freeze at col 100, row 10.
        found = 0;
        for (int n = 0; n < 20000 && found == 0; n++) begin
            step();
            if (col0 == 10'd100 && row0 == 10'd10 && !np0) found = 1;
        end
        chk("reach_c100_r10", found, 1);
        en_v[0] = 1'b0;
        frz_ok = 1; nstr = 0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (col0 != 10'd100 || row0 != 10'd10) frz_ok = 0;
            if (np0 || nl0 || nf0) nstr++;
        end
        chk("freeze_pos", frz_ok, 1);
        chk("freeze_strobes", nstr, 0);
        en_v[0] = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            step();
            if (col0 == 10'd101) lat = n;
        end
        chk("resume_latency", lat, 2);

        // Divider 1, three extra delay stages.
        rst_v[1] = 1'b0;
        en_v[1]  = 1'b1;
        prevh = 1; prevc = 0; fall = 0; fcol = -1; fprev = -1; v3 = -1; v4 = -1;
        for (int n = 1; n <= 2000 && fall == 0; n++) begin
            step();
            if (n == 3) v3 = int'(vis1);
            if (n == 4) v4 = int'(vis1);
            if (prevh == 1 && !hs1) begin
                fall  = n;
                fcol  = int'(col1);
                fprev = prevc;
            end
            prevh = int'(hs1);
            prevc = int'(col1);
        end
        chk("dly_vis_clk3", v3, 0);
        chk("dly_vis_clk4", v4, 1);
        chk("hs_fall_clk", fall, 660);
        chk("hs_fall_col", fcol, 656);
        chk("hs_fall_prev_col", fprev, 655);

        // Small 8x5 timing, active-high syncs: frame period, wrap and sync windows.
        rst_v[2] = 1'b0;
        en_v[2]  = 1'b1;
        nfc = 0; vsc = 0; vbad = 0; hsc = 0; visc = 0;
        for (int n = 1; n <= 740; n++) begin
            step();
            if (nfc == 1) begin
                if (vs2) begin
                    vsc++;
                    if (row2 != 3'd3) vbad++;
                end
                if (hs2) hsc++;
                if (np2 && vis2) visc++;
            end
            if (nf2) begin
                nfc++;
                if (nfc <= 9) begin
                    nfi[nfc] = n;
                    fcs[nfc] = int'(fc2);
                end
            end
        end
        chk("nf_first", nfi[1], 81);
        chk("nf_period", nfi[2] - nfi[1], 80);
        chk("fc_at_nf1", fcs[1], 0);
        chk("fc_at_nf8", fcs[8], 7);
        chk("fc_at_nf9_wrap", fcs[9], 0);
        chk("vs_active_clks", vsc, 16);
        chk("vs_wrong_row", vbad, 0);
        chk("hs_active_clks", hsc, 10);
        chk("visible_pixels", visc, 8);

        // Reset while vsync is active.
        found = 0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            step();
            if (vs2 && row2 == 3'd3) found = 1;
        end
        chk("reach_vsync", found, 1);
        rst_v[2] = 1'b1;
        step();
        chk("rstmid_vsync", int'(vs2), 0);
        chk("rstmid_col", int'(col2), 0);
        chk("rstmid_row", int'(row2), 0);
        chk("rstmid_vis", int'(vis2), 0);
        chk("rstmid_fc", int'(fc2), 0);
        rst_v[2] = 1'b0;
        nf_re = 0;
        for (int n = 1; n <= 100 && nf_re == 0; n++) begin
            step();
            if (nf2) nf_re = n;
        end
        chk("restart_nf", nf_re, 81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
